// File: rtl/ppi_pkg.sv
// Shared constants and FSM state type for the PPI read/write control slice.
package ppi_pkg;

    localparam logic [1:0] PPI_ADDR_PA = 2'd0;
    localparam logic [1:0] PPI_ADDR_PB = 2'd1;
    localparam logic [1:0] PPI_ADDR_PC = 2'd2;
    localparam logic [1:0] PPI_ADDR_CW = 2'd3;

    // All ports input, mode 0.
    localparam logic [7:0] PPI_MODE_RESET = 8'h9B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_HOLD  = 2'd3
    } ppi_rw_state_t;

endpackage

// File: rtl/ppi_rw_ctrl_if.sv
// CPU bus and port-side signals of the read/write control stage.
interface ppi_rw_ctrl_if;

    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] d_in;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic [7:0] pc_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] wr_data;
    logic       pa_wr;
    logic       pb_wr;
    logic       pc_wr;
    logic       cw_en;
    logic [7:0] mode_word;
    logic       bsr_en;
    logic [2:0] bsr_bit;
    logic       bsr_val;

    modport slave (
        input  cs_n, rd_n, wr_n, addr, d_in, pa_in, pb_in, pc_in,
        output d_out, d_oe, wr_data, pa_wr, pb_wr, pc_wr, cw_en,
               mode_word, bsr_en, bsr_bit, bsr_val
    );

    modport master (
        output cs_n, rd_n, wr_n, addr, d_in, pa_in, pb_in, pc_in,
        input  d_out, d_oe, wr_data, pa_wr, pb_wr, pc_wr, cw_en,
               mode_word, bsr_en, bsr_bit, bsr_val
    );

endinterface

// File: rtl/ppi_sync.sv
// Single-bit multi-flop synchronizer; resets to 1 so active-low strobes read inactive.
module ppi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_rw_ctrl.sv
// PPI read/write control: strobe synchronization, access FSM, write commit decode
// and registered read-data mux.
module ppi_rw_ctrl
    import ppi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    ppi_rw_ctrl_if.slave  bus
);

    logic cs_s, rd_s, wr_s;
    logic sel, w, r;

    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_s));
    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst(rst), .d(bus.rd_n), .q(rd_s));
    ppi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst(rst), .d(bus.wr_n), .q(wr_s));

    assign sel = ~cs_s;
    assign w   = sel & ~wr_s;
    assign r   = sel & ~rd_s;

    ppi_rw_state_t state_q, state_d;
    logic [1:0] shadow_addr_q, shadow_addr_d;
    logic [7:0] shadow_data_q, shadow_data_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       pa_wr_q, pa_wr_d, pb_wr_q, pb_wr_d, pc_wr_q, pc_wr_d;
    logic       cw_en_q, cw_en_d, bsr_en_q, bsr_en_d;
    logic [7:0] mode_word_q, mode_word_d;
    logic [2:0] bsr_bit_q, bsr_bit_d;
    logic       bsr_val_q, bsr_val_d;
    logic       commit;

    always_comb begin
        state_d       = state_q;
        shadow_addr_d = shadow_addr_q;
        shadow_data_d = shadow_data_q;
        d_out_d       = d_out_q;
        commit        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (w && r)       state_d = ST_HOLD;
                else if (w)       state_d = ST_WRITE;
                else if (r)       state_d = ST_READ;
            end
            ST_WRITE: begin
                shadow_addr_d = bus.addr;
                shadow_data_d = bus.d_in;
                if (r) begin
                    state_d = ST_HOLD;
                end else if (!w) begin
                    state_d = ST_IDLE;
                    commit  = 1'b1;
                end
            end
            ST_READ: begin
                unique case (bus.addr)
                    PPI_ADDR_PA: d_out_d = bus.pa_in;
                    PPI_ADDR_PB: d_out_d = bus.pb_in;
                    PPI_ADDR_PC: d_out_d = bus.pc_in;
                    default:     d_out_d = mode_word_q;
                endcase
                if (w)            state_d = ST_HOLD;
                else if (!r)      state_d = ST_IDLE;
            end
            default: begin
                if (!w && !r)     state_d = ST_IDLE;
            end
        endcase
    end

    // Commit decode uses the shadow copy taken on the last WRITE cycle, so the
    // pulses and their side data appear together one clock after release.
    always_comb begin
        d_oe_d      = (state_q == ST_READ);
        wr_data_d   = wr_data_q;
        mode_word_d = mode_word_q;
        bsr_bit_d   = bsr_bit_q;
        bsr_val_d   = bsr_val_q;
        pa_wr_d     = 1'b0;
        pb_wr_d     = 1'b0;
        pc_wr_d     = 1'b0;
        cw_en_d     = 1'b0;
        bsr_en_d    = 1'b0;

        if (commit) begin
            wr_data_d = shadow_data_q;
            unique case (shadow_addr_q)
                PPI_ADDR_PA: pa_wr_d = 1'b1;
                PPI_ADDR_PB: pb_wr_d = 1'b1;
                PPI_ADDR_PC: pc_wr_d = 1'b1;
                default: begin
                    if (shadow_data_q[7]) begin
                        cw_en_d     = 1'b1;
                        mode_word_d = shadow_data_q;
                    end else begin
                        bsr_en_d  = 1'b1;
                        bsr_bit_d = shadow_data_q[3:1];
                        bsr_val_d = shadow_data_q[0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
            d_out_q       <= '0;
            d_oe_q        <= 1'b0;
            wr_data_q     <= '0;
            pa_wr_q       <= 1'b0;
            pb_wr_q       <= 1'b0;
            pc_wr_q       <= 1'b0;
            cw_en_q       <= 1'b0;
            bsr_en_q      <= 1'b0;
            mode_word_q   <= PPI_MODE_RESET;
            bsr_bit_q     <= '0;
            bsr_val_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_data_q <= shadow_data_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            wr_data_q     <= wr_data_d;
            pa_wr_q       <= pa_wr_d;
            pb_wr_q       <= pb_wr_d;
            pc_wr_q       <= pc_wr_d;
            cw_en_q       <= cw_en_d;
            bsr_en_q      <= bsr_en_d;
            mode_word_q   <= mode_word_d;
            bsr_bit_q     <= bsr_bit_d;
            bsr_val_q     <= bsr_val_d;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.d_oe      = d_oe_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.pa_wr     = pa_wr_q;
    assign bus.pb_wr     = pb_wr_q;
    assign bus.pc_wr     = pc_wr_q;
    assign bus.cw_en     = cw_en_q;
    assign bus.mode_word = mode_word_q;
    assign bus.bsr_en    = bsr_en_q;
    assign bus.bsr_bit   = bsr_bit_q;
    assign bus.bsr_val   = bsr_val_q;

endmodule

// File: tb/tb_ppi_rw_ctrl.sv
// Directed bench for ppi_rw_ctrl with SYNC_STAGES = 2; expected values are hand-derived.
module tb_ppi_rw_ctrl;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_PA   = 5'b10000;
    localparam logic [4:0] P_PB   = 5'b01000;
    localparam logic [4:0] P_PC   = 5'b00100;
    localparam logic [4:0] P_CW   = 5'b00010;
    localparam logic [4:0] P_BSR  = 5'b00001;

    ppi_rw_ctrl_if bus ();

    ppi_rw_ctrl #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] pulse_v;
    assign pulse_v = {bus.pa_wr, bus.pb_wr, bus.pc_wr, bus.cw_en, bus.bsr_en};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
    endtask

    // Strobes low for 6 clocks, released together; pulse expected on the 3rd clock.
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d,
                             input logic [4:0] exp_pulse, input string tag);
        bus.addr = a;
        bus.d_in = d;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        tick(6);
        bus_idle();
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check($sformatf("%s_pulse%0d", tag, k), pulse_v, (k == 3) ? exp_pulse : P_NONE);
        end
        check($sformatf("%s_wr_data", tag), bus.wr_data, d);
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
        bus.addr = a;
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        tick(5);
        check($sformatf("%s_d_out", tag), bus.d_out, exp);
        check($sformatf("%s_d_oe", tag), bus.d_oe, 1'b1);
        check($sformatf("%s_nopulse", tag), pulse_v, P_NONE);
        bus_idle();
        tick(2);
        check($sformatf("%s_oe_hold", tag), bus.d_oe, 1'b1);
        tick(2);
        check($sformatf("%s_oe_fall", tag), bus.d_oe, 1'b0);
        check($sformatf("%s_d_out_hold", tag), bus.d_out, exp);
    endtask

    initial begin
        rst        = 1'b1;
        bus.cs_n   = 1'b0;
        bus.wr_n   = 1'b0;
        bus.rd_n   = 1'b1;
        bus.addr   = 2'd0;
        bus.d_in   = 8'h00;
        bus.pa_in  = 8'h11;
        bus.pb_in  = 8'hC3;
        bus.pc_in  = 8'h7E;

        tick(3);
        check("rst_pulses", pulse_v, P_NONE);
        check("rst_mode", bus.mode_word, 8'h9B);
        check("rst_d_oe", bus.d_oe, 1'b0);
        check("rst_d_out", bus.d_out, 8'h00);
        check("rst_wr_data", bus.wr_data, 8'h00);
        check("rst_bsr", {bus.bsr_bit, bus.bsr_val}, 4'h0);
        bus_idle();
        rst = 1'b0;
        tick(2);
        check("post_rst_pulses", pulse_v, P_NONE);

        cpu_write(2'd0, 8'h5A, P_PA, "wr_pa");
        check("wr_pa_mode", bus.mode_word, 8'h9B);
        cpu_write(2'd1, 8'hA5, P_PB, "wr_pb");

        cpu_write(2'd3, 8'h80, P_CW, "wr_cw");
        check("wr_cw_mode", bus.mode_word, 8'h80);
        cpu_read(2'd3, 8'h80, "rd_cw");

        cpu_write(2'd3, 8'h0B, P_BSR, "bsr1");
        check("bsr1_bit", bus.bsr_bit, 3'd5);
        check("bsr1_val", bus.bsr_val, 1'b1);
        check("bsr1_mode", bus.mode_word, 8'h80);
        cpu_write(2'd3, 8'h0C, P_BSR, "bsr0");
        check("bsr0_bit", bus.bsr_bit, 3'd6);
        check("bsr0_val", bus.bsr_val, 1'b0);

        cpu_read(2'd1, 8'hC3, "rd_pb");
        cpu_read(2'd0, 8'h11, "rd_pa");
        cpu_read(2'd2, 8'h7E, "rd_pc");

        // Read strobe arriving during an active write aborts it.
        bus.addr = 2'd2;
        bus.d_in = 8'h33;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        tick(6);
        bus.rd_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check($sformatf("conf_pulse%0d", k), pulse_v, P_NONE);
            check($sformatf("conf_oe%0d", k), bus.d_oe, 1'b0);
        end
        bus_idle();
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check($sformatf("conf_rel_pulse%0d", k), pulse_v, P_NONE);
            check($sformatf("conf_rel_oe%0d", k), bus.d_oe, 1'b0);
        end
        check("conf_wr_data", bus.wr_data, 8'h0C);
        cpu_write(2'd2, 8'h44, P_PC, "wr_pc");

        // Reset in the middle of a write discards it.
        bus.addr = 2'd0;
        bus.d_in = 8'hEE;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(1);
        bus_idle();
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("rstwr_pulse%0d", k), pulse_v, P_NONE);
        end
        check("rstwr_mode", bus.mode_word, 8'h9B);
        check("rstwr_wr_data", bus.wr_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
